// File: rtl/operand_fetch_stage.sv
// SimpleRISC operand-fetch stage: decode, register-file read, immediate/branch-target build,
// OF/EX pipeline register and load-use interlock. Optional WB bypass under `OF_WB_BYPASS_EN.
module operand_fetch_stage #(
  parameter int RA_REG          = 15,
  parameter int LD_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        of_ready,
  output logic [3:0]  rf_rs1,
  output logic [3:0]  rf_rs2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  input  logic        wb_en,
  input  logic [3:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_btarget,
  output logic [3:0]  ex_rd,
  output logic        ex_is_ld
);

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010,
                         OP_DIV = 5'b00011, OP_MOD = 5'b00100, OP_CMP = 5'b00101,
                         OP_AND = 5'b00110, OP_OR  = 5'b00111, OP_NOT = 5'b01000,
                         OP_MOV = 5'b01001, OP_LSL = 5'b01010, OP_LSR = 5'b01011,
                         OP_ASR = 5'b01100, OP_LD  = 5'b01110, OP_ST  = 5'b01111,
                         OP_CALL = 5'b10011, OP_RET = 5'b10100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] btarget;
    logic [3:0]  rd;
    logic        is_ld;
  } ofex_t;

  logic [4:0]  opc;
  logic        imm_f;
  logic [3:0]  rd_f, rs1_f, rs2_f;
  logic        use1, use2;
  logic [31:0] imm, src1, src2;
  logic        stall, accept;
  logic [3:0]  ld_rd;
  logic [1:0]  ld_cnt;
  ofex_t       ex_q, ex_d;

  assign opc   = if_inst[31:27];
  assign imm_f = if_inst[26];
  assign rd_f  = if_inst[25:22];
  assign rs1_f = if_inst[21:18];
  assign rs2_f = if_inst[17:14];

  assign rf_rs1 = (opc == OP_RET) ? 4'(RA_REG) : rs1_f;
  assign rf_rs2 = (opc == OP_ST)  ? rd_f       : rs2_f;

  // Only sources the opcode actually reads may trigger the load-use interlock.
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (opc)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_CMP, OP_AND, OP_OR,
      OP_LSL, OP_LSR, OP_ASR: begin use1 = 1'b1; use2 = ~imm_f; end
      OP_NOT, OP_MOV:         use2 = ~imm_f;
      OP_LD, OP_RET:          use1 = 1'b1;
      OP_ST:                  begin use1 = 1'b1; use2 = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    case (if_inst[17:16])
      2'b01:   imm = {16'h0, if_inst[15:0]};
      2'b10:   imm = {if_inst[15:0], 16'h0};
      default: imm = {{16{if_inst[15]}}, if_inst[15:0]};
    endcase
  end

`ifdef OF_WB_BYPASS_EN
  assign src1 = (wb_en && (wb_rd == rf_rs1)) ? wb_data : rf_rd1;
  assign src2 = (wb_en && (wb_rd == rf_rs2)) ? wb_data : rf_rd2;
`else
  // Register-file write-through already covers same-cycle writeback.
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_rd, wb_data};
  assign src1 = rf_rd1;
  assign src2 = rf_rd2;
`endif

  always_comb begin
    ex_d.pc      = if_pc;
    ex_d.inst    = if_inst;
    ex_d.op1     = src1;
    ex_d.op2     = (imm_f && (opc != OP_ST)) ? imm : src2;
    ex_d.imm     = imm;
    ex_d.btarget = if_pc + {{3{if_inst[26]}}, if_inst[26:0], 2'b00};
    ex_d.rd      = (opc == OP_CALL) ? 4'(RA_REG) : rd_f;
    ex_d.is_ld   = (opc == OP_LD);
  end

  assign stall    = (ld_cnt != 2'd0) & if_valid &
                    ((use1 & (rf_rs1 == ld_rd)) | (use2 & (rf_rs2 == ld_rd)));
  assign of_ready = rst_n & ~stall & ~flush & (~ex_valid | ex_ready);
  assign accept   = if_valid & of_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
      ld_cnt   <= 2'd0;
      ld_rd    <= 4'd0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ld_cnt   <= 2'd0;
    end else begin
      // A fresh load handoff overrides any interlock still counting down.
      if (ex_valid && ex_ready && ex_q.is_ld) begin
        ld_rd  <= ex_q.rd;
        ld_cnt <= 2'(LD_STALL_CYCLES);
      end else if (ld_cnt != 2'd0) begin
        ld_cnt <= ld_cnt - 2'd1;
      end
      if (accept) begin
        ex_q     <= ex_d;
        ex_valid <= 1'b1;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

  assign ex_pc      = ex_q.pc;
  assign ex_inst    = ex_q.inst;
  assign ex_op1     = ex_q.op1;
  assign ex_op2     = ex_q.op2;
  assign ex_imm     = ex_q.imm;
  assign ex_btarget = ex_q.btarget;
  assign ex_rd      = ex_q.rd;
  assign ex_is_ld   = ex_q.is_ld;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: vector table plus hand sequences for interlock,
// backpressure, flush, reset and (under OF_WB_BYPASS_EN) writeback bypass.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;
  logic        of_ready;
  logic [3:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_inst, ex_op1, ex_op2, ex_imm, ex_btarget;
  logic [3:0]  ex_rd;
  logic        ex_is_ld;

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .of_ready(of_ready), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_btarget(ex_btarget),
    .ex_rd(ex_rd), .ex_is_ld(ex_is_ld)
  );

  always #5 clk = ~clk;

  // r0=0, r1=2, r2=5, every other ri = 0xA0+i
  logic [31:0] rf [16];
  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'hA0 + 32'(i);
    rf[0] = 32'd0;
    rf[1] = 32'd2;
    rf[2] = 32'd5;
  end
  assign rf_rd1 = rf[rf_rs1];
  assign rf_rd2 = rf[rf_rs2];

  // chk bits: 0 op1, 1 op2, 2 imm, 3 btarget, 4 rd
  typedef struct {
    logic [31:0] inst, pc, op1, op2, imm, bt;
    logic [3:0]  rd;
    logic        is_ld;
    logic [4:0]  chk;
  } vec_t;

  vec_t expq[$];
  vec_t vt [12];
  vec_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, 1'b0, rd, rs1, rs2, 14'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [1:0] md,
                                        input logic [15:0] im);
    return {op, 1'b1, rd, rs1, md, im};
  endfunction

  // Scoreboard: every handoff to EX pops the oldest accepted instruction.
  always @(negedge clk) begin
    if (!rst_n) expq.delete();
    else if (flush) begin
      if (ex_valid && expq.size() > 0) void'(expq.pop_front());
    end else if (ex_valid && ex_ready) begin
      if (expq.size() == 0) chk("unexpected_handoff", 32'd1, 32'd0);
      else begin
        mon_e = expq.pop_front();
        chk("ex_pc", ex_pc, mon_e.pc);
        chk("ex_inst", ex_inst, mon_e.inst);
        chk("ex_is_ld", 32'(ex_is_ld), 32'(mon_e.is_ld));
        if (mon_e.chk[0]) chk("ex_op1", ex_op1, mon_e.op1);
        if (mon_e.chk[1]) chk("ex_op2", ex_op2, mon_e.op2);
        if (mon_e.chk[2]) chk("ex_imm", ex_imm, mon_e.imm);
        if (mon_e.chk[3]) chk("ex_btarget", ex_btarget, mon_e.bt);
        if (mon_e.chk[4]) chk("ex_rd", 32'(ex_rd), 32'(mon_e.rd));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input vec_t v, output int stalls);
    if_valid = 1'b1;
    if_inst  = v.inst;
    if_pc    = v.pc;
    stalls   = 0;
    forever begin
      @(negedge clk);
      if (of_ready) break;
      stalls++;
      if (stalls >= 40) break;
    end
    if (of_ready) expq.push_back(v);
    else chk("issue_timeout", 32'(stalls), 32'd0);
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  vec_t ldv, dep, unrel, stv, movv, x;
  int st;

  task automatic ld_then(input vec_t d, input int exp_stall, input string name);
    int s;
    issue(ldv, s);
    @(posedge clk); #1;          // load hands off to EX this cycle
    issue(d, s);
    chk(name, 32'(s), 32'(exp_stall));
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b1; if_inst = 32'h0; if_pc = 32'h0;
    wb_en = 1'b0; wb_rd = 4'd0; wb_data = 32'd0; flush = 1'b0; ex_ready = 1'b1;

    vt[0]  = '{enc_r(5'b00000, 4'd3, 4'd1, 4'd2), 32'h10, 32'd2, 32'd5, 32'h0, 32'h0, 4'd3, 1'b0, 5'b10011};
    vt[1]  = '{enc_i(5'b01001, 4'd4, 4'd0, 2'b00, 16'hFFFE), 32'h14, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0, 4'd4, 1'b0, 5'b10111};
    vt[2]  = '{enc_i(5'b01001, 4'd4, 4'd0, 2'b01, 16'hFFFE), 32'h18, 32'd0, 32'h0000FFFE, 32'h0000FFFE, 32'h0, 4'd4, 1'b0, 5'b10111};
    vt[3]  = '{enc_i(5'b01001, 4'd4, 4'd0, 2'b10, 16'hFFFE), 32'h1C, 32'd0, 32'hFFFE0000, 32'hFFFE0000, 32'h0, 4'd4, 1'b0, 5'b10111};
    vt[4]  = '{enc_i(5'b01001, 4'd4, 4'd0, 2'b11, 16'hFFFE), 32'h20, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0, 4'd4, 1'b0, 5'b10111};
    vt[5]  = '{enc_i(5'b00001, 4'd5, 4'd6, 2'b00, 16'h0007), 32'h24, 32'hA6, 32'd7, 32'd7, 32'h0, 4'd5, 1'b0, 5'b10111};
    vt[6]  = '{enc_i(5'b01111, 4'd7, 4'd8, 2'b00, 16'h0008), 32'h28, 32'hA8, 32'hA7, 32'd8, 32'h0, 4'd7, 1'b0, 5'b10111};
    vt[7]  = '{enc_r(5'b10100, 4'd0, 4'd0, 4'd0), 32'h2C, 32'hAF, 32'd0, 32'h0, 32'h0, 4'd0, 1'b0, 5'b00011};
    vt[8]  = '{enc_i(5'b01110, 4'd9, 4'd1, 2'b00, 16'h0004), 32'h30, 32'd2, 32'd4, 32'd4, 32'h0, 4'd9, 1'b1, 5'b10111};
    vt[9]  = '{32'h90000003, 32'h100, 32'h0, 32'h0, 32'h0, 32'h10C, 4'd0, 1'b0, 5'b01000};
    vt[10] = '{32'h9FFFFFFE, 32'h200, 32'h0, 32'h0, 32'h0, 32'h1F8, 4'd15, 1'b0, 5'b11000};
    vt[11] = '{32'h80000010, 32'h40, 32'h0, 32'h0, 32'h0, 32'h80, 4'd0, 1'b0, 5'b01000};

    ldv   = '{enc_i(5'b01110, 4'd4, 4'd2, 2'b00, 16'h0), 32'h300, 32'd5, 32'd0, 32'd0, 32'h0, 4'd4, 1'b1, 5'b10111};
    dep   = '{enc_r(5'b00000, 4'd5, 4'd4, 4'd1), 32'h304, 32'hA4, 32'd2, 32'h0, 32'h0, 4'd5, 1'b0, 5'b10011};
    unrel = '{enc_r(5'b00000, 4'd8, 4'd6, 4'd7), 32'h308, 32'hA6, 32'hA7, 32'h0, 32'h0, 4'd8, 1'b0, 5'b10011};
    stv   = '{enc_i(5'b01111, 4'd4, 4'd1, 2'b00, 16'h0), 32'h30C, 32'd2, 32'hA4, 32'd0, 32'h0, 4'd4, 1'b0, 5'b10111};
    movv  = '{enc_i(5'b01001, 4'd3, 4'd4, 2'b00, 16'h1), 32'h310, 32'h0, 32'd1, 32'd1, 32'h0, 4'd3, 1'b0, 5'b10110};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_of_ready", 32'(of_ready), 32'd0);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_op1", ex_op1, 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; if_valid = 1'b0;

    // vector table, back to back
    for (int i = 0; i < 12; i++) issue(vt[i], st);
    repeat (3) @(posedge clk); #1;

    // load-use interlock
    ld_then(dep, 1, "ld_use_stall");
    ld_then(unrel, 0, "ld_unrelated_stall");
    ld_then(stv, 1, "ld_st_data_stall");
    ld_then(movv, 0, "ld_unused_src_stall");
    repeat (3) @(posedge clk); #1;

    // EX backpressure for 3 cycles
    ex_ready = 1'b0;
    issue(vt[0], st);
    if_valid = 1'b1; if_inst = vt[5].inst; if_pc = vt[5].pc;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_of_ready", 32'(of_ready), 32'd0);
      chk("bp_ex_valid", 32'(ex_valid), 32'd1);
      chk("bp_ex_pc_hold", ex_pc, vt[0].pc);
      chk("bp_ex_op2_hold", ex_op2, 32'd5);
    end
    @(posedge clk); #1;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_of_ready", 32'(of_ready), 32'd1);
    if (of_ready) expq.push_back(vt[5]);
    @(posedge clk); #1;
    if_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // flush with ex_valid=1 and an interlock pending
    issue(ldv, st);
    issue(unrel, st);
    flush = 1'b1;
    if_valid = 1'b1; if_inst = dep.inst; if_pc = dep.pc;
    @(negedge clk);
    chk("flush_of_ready", 32'(of_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    chk("flush_no_stall", 32'(of_ready), 32'd1);
    if (of_ready) expq.push_back(dep);
    @(posedge clk); #1;
    if_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // reset mid-stream
    issue(ldv, st);
    issue(unrel, st);
    rst_n = 1'b0;
    if_valid = 1'b1; if_inst = dep.inst; if_pc = dep.pc;
    @(negedge clk);
    chk("mid_rst_of_ready", 32'(of_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_ex_pc", ex_pc, 32'd0);
    chk("mid_rst_ex_inst", ex_inst, 32'd0);
    chk("mid_rst_ex_op1", ex_op1, 32'd0);
    chk("mid_rst_ex_op2", ex_op2, 32'd0);
    chk("mid_rst_ex_imm", ex_imm, 32'd0);
    chk("mid_rst_ex_bt", ex_btarget, 32'd0);
    chk("mid_rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("mid_rst_ex_is_ld", 32'(ex_is_ld), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_stall", 32'(of_ready), 32'd1);
    if (of_ready) expq.push_back(dep);
    @(posedge clk); #1;
    if_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // writeback bypass (or its absence)
    wb_en = 1'b1; wb_rd = 4'd1; wb_data = 32'd99;
    x = vt[0];
`ifdef OF_WB_BYPASS_EN
    x.op1 = 32'd99;
`endif
    issue(x, st);
    wb_rd = 4'd2; wb_data = 32'd77;
    x = vt[0]; x.pc = 32'h44;
`ifdef OF_WB_BYPASS_EN
    x.op2 = 32'd77;
`endif
    issue(x, st);
    wb_en = 1'b0;

    repeat (4) @(posedge clk); #1;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
